// File: rtl/uart_apb_pkg.sv
// Shared constants for the CoreUART APB poller: slave register map,
// STATUS bit positions and the poller state encoding.
package uart_apb_pkg;

  localparam logic [4:0] ADDR_TX     = 5'h00;
  localparam logic [4:0] ADDR_RX     = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam int STAT_TXRDY    = 0;
  localparam int STAT_RXRDY    = 1;
  localparam int STAT_PARITY   = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_FRAMING  = 4;

  typedef enum logic [2:0] {INIT1, INIT2, POLL, RXRD, TXWR} state_t;

  function automatic logic [4:0] state_addr(input state_t s);
    case (s)
      INIT1:   return ADDR_CTRL1;
      INIT2:   return ADDR_CTRL2;
      RXRD:    return ADDR_RX;
      TXWR:    return ADDR_TX;
      default: return ADDR_STATUS;
    endcase
  endfunction

  function automatic logic state_is_write(input state_t s);
    return (s == INIT1) || (s == INIT2) || (s == TXWR);
  endfunction

endpackage

// File: rtl/apb_master_phase.sv
// APB SETUP/ACCESS sequencer: drives PSEL/PENABLE, flags completion and
// tells the caller when to present address/data for the next SETUP.
module apb_master_phase (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic req,
  input  logic pready,
  output logic psel,
  output logic penable,
  output logic done,
  output logic launch
);

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_ACCESS = 2'd2;

  logic [1:0] phase_q;
  logic [1:0] phase_d;

  assign psel    = (phase_q != PH_IDLE);
  assign penable = (phase_q == PH_ACCESS);
  assign done    = (phase_q == PH_ACCESS) && pready;
  // launch is high in the cycle before a SETUP, so the next transfer
  // starts back-to-back with the completing one.
  assign launch  = req && ((phase_q == PH_IDLE) || done);

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:   if (req) phase_d = PH_SETUP;
      PH_SETUP:  phase_d = PH_ACCESS;
      PH_ACCESS: if (pready) phase_d = req ? PH_SETUP : PH_IDLE;
      default:   phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) phase_q <= PH_IDLE;
    else          phase_q <= phase_d;
  end

endmodule

// File: rtl/uart_apb_poller.sv
// APB master that programs CoreUART, then polls STATUS and moves bytes
// between the UART data registers and two valid/ready byte streams.
module uart_apb_poller
  import uart_apb_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE   = 13'd1,
  parameter bit          BIT8         = 1'b1,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter bit          PROGRAM_CTRL = 1'b1
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] M_PADDR,
  output logic       M_PSEL,
  output logic       M_PENABLE,
  output logic       M_PWRITE,
  output logic [7:0] M_PWDATA,
  input  logic [7:0] M_PRDATA,
  input  logic       M_PREADY,
  input  logic       M_PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [3:0] err_sticky,
  input  logic       err_clr,
  output logic       init_done
);

  // Streams: tx is consumed by a one-cycle tx_ready pulse (tx_data must stay
  // stable while tx_valid is high); rx_valid holds until rx_valid && rx_ready.
  localparam state_t RESET_STATE = PROGRAM_CTRL ? INIT1 : POLL;

  state_t     state_q;
  state_t     next_state;
  state_t     target;
  logic       done;
  logic       launch;
  logic [7:0] wdata_sel;
  logic [3:0] err_set;

  apb_master_phase u_phase (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .req     (1'b1),
    .pready  (M_PREADY),
    .psel    (M_PSEL),
    .penable (M_PENABLE),
    .done    (done),
    .launch  (launch)
  );

  // Decided from M_PRDATA in the completion cycle so the next SETUP
  // follows immediately.
  always_comb begin
    next_state = state_q;
    case (state_q)
      INIT1: next_state = INIT2;
      INIT2: next_state = POLL;
      POLL: begin
        if (M_PRDATA[STAT_RXRDY] && !rx_valid)      next_state = RXRD;
        else if (M_PRDATA[STAT_TXRDY] && tx_valid)  next_state = TXWR;
        else                                        next_state = POLL;
      end
      default: next_state = POLL;
    endcase
  end

  assign target = done ? next_state : state_q;

  always_comb begin
    wdata_sel = tx_data;
    case (target)
      INIT1:   wdata_sel = BAUD_VALUE[7:0];
      INIT2:   wdata_sel = {BAUD_VALUE[12:8], PARITY_ODD, PARITY_EN, BIT8};
      default: wdata_sel = tx_data;
    endcase
  end

  assign err_set  = {done && M_PSLVERR,
                     (done && state_q == POLL) ? M_PRDATA[STAT_FRAMING:STAT_PARITY] : 3'b000};
  assign tx_ready = done && (state_q == TXWR);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= RESET_STATE;
      M_PADDR    <= 5'h00;
      M_PWRITE   <= 1'b0;
      M_PWDATA   <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      err_sticky <= 4'h0;
      init_done  <= 1'b0;
    end else begin
      if (done) state_q <= next_state;
      if (launch) begin
        M_PADDR  <= state_addr(target);
        M_PWRITE <= state_is_write(target);
        if (state_is_write(target)) M_PWDATA <= wdata_sel;
      end
      if (!PROGRAM_CTRL || (done && state_q == INIT2)) init_done <= 1'b1;
      if (done && state_q == RXRD) begin
        rx_data  <= M_PRDATA;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A flag raised in the same cycle as err_clr survives the clear.
      err_sticky <= err_set | (err_clr ? 4'h0 : err_sticky);
    end
  end

endmodule
